// File: rtl/des_job_scheduler.sv
// Job scheduler for replicated DES search cores: cuts one job into 2^CHUNK_BITS-seed
// chunks, keeps every core busy and folds the per-core match counters into a job total.
module des_job_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_start,
    input  logic [63:0]             job_seed,
    input  logic [31:0]             job_chunks,
    input  logic                    abort,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [64*NUM_CORES-1:0] core_counter,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_restart,
    output logic [63:0]             core_seed,
    output logic                    busy,
    output logic                    job_done,
    output logic [63:0]             total_count,
    output logic [1:0]              state_dbg
);

    // Core handshake: core_start[i] is a one-cycle request carrying core_seed; the core
    // answers with a done level that is held until the one-cycle core_restart[i] retires it.
    // core_done[i] and its counter are trusted only while core i is marked active.

    localparam logic [63:0] SEED_STEP = 64'd1 << CHUNK_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [63:0]          next_seed, next_seed_n;
    logic [31:0]          remaining, remaining_n;
    logic [NUM_CORES-1:0] active, active_n;
    logic [NUM_CORES-1:0] cool, cool_n;
    logic [NUM_CORES-1:0] start_n, restart_n;
    logic [63:0]          seed_n, total_n;
    logic                 busy_n, job_done_n;
    logic [NUM_CORES-1:0] collect_mask, dispatch_mask;
    logic [63:0]          collect_val;

    assign state_dbg = state;

    // Lowest-index finished core; scanning downward lets the lowest hit win.
    always_comb begin
        collect_mask = '0;
        collect_val  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (active[i] && core_done[i]) begin
                collect_mask    = '0;
                collect_mask[i] = 1'b1;
                collect_val     = core_counter[64*i +: 64];
            end
        end
    end

    always_comb begin
        dispatch_mask = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (!active[j] && !cool[j] && !collect_mask[j]) begin
                dispatch_mask    = '0;
                dispatch_mask[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        next_seed_n = next_seed;
        remaining_n = remaining;
        active_n    = active;
        cool_n      = '0;
        start_n     = '0;
        restart_n   = '0;
        seed_n      = core_seed;
        total_n     = total_count;
        job_done_n  = job_done;
        case (state)
            S_IDLE, S_DONE: begin
                if (job_start) begin
                    next_seed_n = job_seed;
                    remaining_n = job_chunks;
                    total_n     = '0;
                    job_done_n  = 1'b0;
                    active_n    = '0;
                    state_n     = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    restart_n   = active;
                    active_n    = '0;
                    remaining_n = '0;
                    state_n     = S_IDLE;
                end else if (remaining == '0 && active == '0) begin
                    job_done_n = 1'b1;
                    state_n    = S_DONE;
                end else begin
                    if (collect_mask != '0) begin
                        total_n   = total_count + collect_val;
                        restart_n = collect_mask;
                        active_n  = active_n & ~collect_mask;
                        // Hold the core off for a cycle while its done level falls.
                        cool_n    = collect_mask;
                    end
                    if (remaining != '0 && dispatch_mask != '0) begin
                        start_n     = dispatch_mask;
                        seed_n      = next_seed;
                        active_n    = active_n | dispatch_mask;
                        next_seed_n = next_seed + SEED_STEP;
                        remaining_n = remaining - 32'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_seed    <= '0;
            remaining    <= '0;
            active       <= '0;
            cool         <= '0;
            core_start   <= '0;
            core_restart <= '0;
            core_seed    <= '0;
            busy         <= 1'b0;
            job_done     <= 1'b0;
            total_count  <= '0;
        end else begin
            next_seed    <= next_seed_n;
            remaining    <= remaining_n;
            active       <= active_n;
            cool         <= cool_n;
            core_start   <= start_n;
            core_restart <= restart_n;
            core_seed    <= seed_n;
            busy         <= busy_n;
            job_done     <= job_done_n;
            total_count  <= total_n;
        end
    end

endmodule

// File: doc/des_job_scheduler.md
# des_job_scheduler

Splits one brute-force job into fixed-size chunks and dispatches them across `NUM_CORES` DES search cores. Each core runs one chunk at a time from a start pulse to its done level. The scheduler sums the per-core 64-bit match counters into one job total. It sits between the command wrapper (job source) and the replicated DES cores, and owns every core's start and restart line.

## Interface
Parameters:
- `NUM_CORES`, 4: number of DES cores under control (1..16).
- `CHUNK_BITS`, 16: each chunk covers 2^CHUNK_BITS consecutive seeds.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `job_start`  in  1  single-cycle pulse; accepted only in IDLE or DONE.
- `job_seed`  in  64  first seed of the job; sampled with `job_start`.
- `job_chunks`  in  32  number of chunks; sampled with `job_start`.
- `abort`  in  1  single-cycle pulse; cancels a running job.
- `core_done`  in  NUM_CORES  per-core done level; held until that core is restarted.
- `core_counter`  in  64*NUM_CORES  packed counters; core i is at [64i+63:64i]; valid while `core_done[i]`.
- `core_start`  out  NUM_CORES  one-cycle start pulse per core.
- `core_restart`  out  NUM_CORES  one-cycle restart pulse per core.
- `core_seed`  out  64  seed for the core started in the same cycle.
- `busy`  out  1  high while in RUN.
- `job_done`  out  1  level; held from completion until the next accepted `job_start`.
- `total_count`  out  64  running/final sum of collected counters.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - DONE.
- Internal state:
  - `next_seed` (64 bits).
  - `remaining` (32 bits).
  - Per core: `active` bit and `cool` bit.
- Accepted `job_start`:
  - `next_seed` takes `job_seed`; `remaining` takes `job_chunks`.
  - `total_count` clears to 0 and `job_done` clears.
  - All `active` and `cool` bits clear; state moves to RUN.
- Collect, in RUN, at most one core per cycle:
  - Target: the lowest index i with `active[i]` and `core_done[i]`.
  - `total_count` becomes `total_count + core_counter[i]`, mod 2^64.
  - Pulse `core_restart[i]`; clear `active[i]`; set `cool[i]`.
- Dispatch, in RUN, at most one core per cycle:
  - Condition: `remaining` != 0.
  - Target: the lowest index j with `active[j]` = 0, `cool[j]` = 0, and j not collected this cycle.
  - Pulse `core_start[j]` with `core_seed` = `next_seed`; set `active[j]`.
  - `next_seed` advances by 2^CHUNK_BITS, mod 2^64; `remaining` decrements by 1.
- Cooldown: a `cool` bit clears one cycle after it is set. This prevents re-dispatching a core whose done level is still falling.
- Collect and dispatch happen in the same cycle when they target different cores.
- `core_done[i]` is ignored while `active[i]` = 0.
- Completion: in RUN, when `remaining` = 0 and no core is `active`, move to DONE and set `job_done`.
- `job_chunks` = 0: RUN completes on its first evaluation.
- Abort in RUN:
  - Pulse `core_restart` for every `active` core in one cycle.
  - Clear all `active` bits and `remaining`; move to IDLE.
  - `job_done` stays 0; `total_count` keeps the partial sum.
- `abort` outside RUN: ignored.
- `job_start` in RUN: ignored.
- `abort` and `job_start` in the same cycle in RUN: abort wins.
- Reset mid-job: everything returns to its reset value immediately. The surrounding system resets the cores separately.

## Timing
- All outputs are registered.
- Reset values:
  - `core_start` = 0, `core_restart` = 0, `core_seed` = 0.
  - `busy` = 0, `job_done` = 0, `total_count` = 0.
  - Internal state = IDLE.
- `job_start` sampled at edge t:
  - `busy` = 1 from cycle t+1.
  - The first dispatch decision is made at edge t+1, so `core_start[0]` is high in cycle t+2 with `core_seed` = `job_seed`.
- Dispatch rate: one core per cycle, so NUM_CORES cores are all running by cycle t+1+NUM_CORES.
- `core_done[i]` seen high at edge u:
  - `core_restart[i]` is high in cycle u+1.
  - `total_count` has the new value in cycle u+1.
  - Core i can be started again at the earliest in cycle u+3.
- Completion: `job_done` = 1 and `busy` = 0 are asserted together, one cycle after the last collection's `core_restart` pulse.
- Abort sampled at edge a: restart pulses are in cycle a+1, and `busy` = 0 from cycle a+1.

## Test plan
- Reset:
  - Stimulus: assert `rst_n` low mid-cycle with no clock edge.
  - Required: all outputs 0 immediately; `job_start` ignored while `rst_n` is low.
- Basic job (NUM_CORES=4, CHUNK_BITS=16):
  - Stimulus: seed 0x1000, chunks 6; each core returns counter 5, 20 cycles after its start.
  - Required: seeds 0x1000, 0x11000, 0x21000, 0x31000 on cores 0..3; then 0x41000 and 0x51000 on the first two cores collected; `total_count` = 30; `job_done` = 1 and `busy` = 0 afterwards.
- Zero chunks:
  - Stimulus: chunks 0.
  - Required: no `core_start`; `job_done` = 1 and `total_count` = 0 within 3 cycles.
- Simultaneous done:
  - Stimulus: cores 1 and 2 raise done in the same cycle with counters 7 and 9.
  - Required: `core_restart[1]` in one cycle, `core_restart[2]` in the next cycle; total grows by 16.
- Abort:
  - Stimulus: `abort` after 3 cores have started and one core has been collected with counter 4.
  - Required: one-cycle restart pulses on the 2 remaining active cores; `busy` = 0; `job_done` = 0; `total_count` = 4; a new `job_start` is then accepted.
- Wrap-around:
  - Stimulus: seed 0xFFFFFFFFFFFF0000, chunks 2; counters 0xFFFFFFFFFFFFFFFF and 2.
  - Required: second seed = 0x0; `total_count` = 1.
